addr_seq_l17: RTL and testbench

//  Loop sequencer for layer 17; sits directly upstream of the layer-17 BRAM1 address generator.

---
 rtl/addr_seq_l17.sv | 162 ++++++++++++++++
 tb/tb_addr_seq_l17.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq_l17.sv
// Layer-17 loop sequencer: walks L/x/y/k per pass and delays x/y/L to the write-back side.
// Optional saturating cycle counter enabled by defining L17_SEQ_CYCLE_CNT_EN.
module addr_seq_l17 #(
   parameter int DELAY = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       u_in,
   input  logic             hold,
   output logic [2:0]       u,
   output logic [2:0]       x,
   output logic [2:0]       y,
   output logic [2:0]       L,
   output logic [1:0]       k,
   output logic [2:0]       x_Reg5,
   output logic [2:0]       y_Reg5,
   output logic [3:0]       z,
   output logic             rd_valid,
   output logic             wr_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int DW = $clog2(DELAY + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t         state, state_nx;
   logic [2:0]     xm, ym, lm;
   logic [1:0]     km;
   logic           last_rd;
   logic [DW-1:0]  drain_cnt;
   logic [DELAY-1:0] v_d;
   logic [2:0]     x_d [DELAY];
   logic [2:0]     y_d [DELAY];
   logic [2:0]     l_d [DELAY];
   logic [2:0]     l_z;

   // Loop bounds follow the latched mode; modes above 5 fall into the mode-4 bounds.
   always_comb begin
      xm = (u <= 3'd1) ? 3'd7 : 3'd3;
      ym = xm;
      lm = (u == 3'd2) ? 3'd3 : 3'd7;
      km = (u == 3'd3) ? 2'd3 : 2'd1;
   end

   assign last_rd  = (k == km) && (y == ym) && (x == xm) && (L == lm);
   assign busy     = (state != IDLE);
   assign rd_valid = (state == RUN) && !hold;
   assign done     = (state == DRAIN) && !hold && (drain_cnt == DW'(DELAY - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (!hold && last_rd) state_nx = DRAIN;
         DRAIN:   if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         u         <= '0;
         x         <= '0;
         y         <= '0;
         L         <= '0;
         k         <= 2'd1;
         drain_cnt <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  u         <= u_in;
                  x         <= '0;
                  y         <= '0;
                  L         <= '0;
                  k         <= 2'd1;
                  drain_cnt <= '0;
               end
            end
            RUN: begin
               // Indices stay parked on the final read once the nest is exhausted.
               if (!hold && !last_rd) begin
                  if (k == km) begin
                     k <= 2'd1;
                     if (y == ym) begin
                        y <= '0;
                        if (x == xm) begin
                           x <= '0;
                           L <= L + 3'd1;
                        end else begin
                           x <= x + 3'd1;
                        end
                     end else begin
                        y <= y + 3'd1;
                     end
                  end else begin
                     k <= k + 2'd1;
                  end
               end
            end
            DRAIN: if (!hold) drain_cnt <= drain_cnt + DW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_d <= '0;
         for (int i = 0; i < DELAY; i++) begin
            x_d[i] <= '0;
            y_d[i] <= '0;
            l_d[i] <= '0;
         end
      end else if (!hold) begin
         v_d[0] <= (state == RUN);
         x_d[0] <= x;
         y_d[0] <= y;
         l_d[0] <= L;
         for (int i = 1; i < DELAY; i++) begin
            v_d[i] <= v_d[i-1];
            x_d[i] <= x_d[i-1];
            y_d[i] <= y_d[i-1];
            l_d[i] <= l_d[i-1];
         end
      end
   end

   assign x_Reg5   = x_d[DELAY-1];
   assign y_Reg5   = y_d[DELAY-1];
   assign wr_valid = v_d[DELAY-1] && !hold;
   assign l_z      = l_d[DELAY-1] + 3'd1;
   // z tracks the delayed stage itself so it stays frozen, not blanked, across a hold.
   assign z = !v_d[DELAY-1]  ? 4'd0 :
              (u == 3'd2)    ? {2'b00, l_z[1:0]} :
                               {1'b0, l_z};

`ifdef L17_SEQ_CYCLE_CNT_EN
   logic [CNT_W-1:0] cnt_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_r <= '0;
      else if (state == IDLE && start)
         cnt_r <= '0;
      else if (busy && cnt_r != '1)
         cnt_r <= cnt_r + CNT_W'(1);
   end

   assign cycle_cnt = cnt_r;
`else
   assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_addr_seq_l17.sv
// Directed bench for addr_seq_l17: table of full passes plus a mid-pass reset sequence.
module tb_addr_seq_l17;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  u_in = '0;
   logic        hold = 1'b0;
   logic [2:0]  u, x, y, L, x_Reg5, y_Reg5;
   logic [1:0]  k;
   logic [3:0]  z;
   logic        rd_valid, wr_valid, busy, done;
   logic [15:0] cycle_cnt;

   int n_checks = 0;
   int n_errors = 0;

   addr_seq_l17 dut (
      .clk(clk), .rst(rst), .start(start), .u_in(u_in), .hold(hold),
      .u(u), .x(x), .y(y), .L(L), .k(k), .x_Reg5(x_Reg5), .y_Reg5(y_Reg5),
      .z(z), .rd_valid(rd_valid), .wr_valid(wr_valid), .busy(busy),
      .done(done), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] u_in;
      int         hold_at;
      int         hold_len;
      bit         start_mid;
      int         exp_reads;
      int         lx, ly, ll, lk;
      int         exp_cycles;
      int         fz, lz;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic run_pass(input vec_t v);
      logic [10:0] exp_q[$];
      logic [8:0]  wr_q[$];
      int          rc_q[$];
      int xm, ym, lm, km, zmod;
      int reads, wrs, cyc, held, first_z, last_z;
      int last_x, last_y, last_l, last_k;
      int exp_cnt;
      bit fin, mid_done, got_wr;
      logic [8:0] w;
      int rc;

      xm   = (v.u_in <= 1) ? 7 : 3;
      ym   = xm;
      lm   = (v.u_in == 2) ? 3 : 7;
      km   = (v.u_in == 3) ? 3 : 1;
      zmod = (v.u_in == 2) ? 4 : 8;
      for (int li = 0; li <= lm; li++)
         for (int xi = 0; xi <= xm; xi++)
            for (int yi = 0; yi <= ym; yi++)
               for (int ki = 1; ki <= km; ki++)
                  exp_q.push_back({3'(xi), 3'(yi), 3'(li), 2'(ki)});

      reads = 0; wrs = 0; cyc = 0; held = 0; first_z = -1; last_z = -1;
      last_x = -1; last_y = -1; last_l = -1; last_k = -1;
      fin = 0; mid_done = 0; got_wr = 0;

      @(negedge clk);
      start = 1'b1;
      u_in  = v.u_in;
      hold  = (v.hold_len > 0 && v.hold_at == 0);
      @(negedge clk);
      start = 1'b0;

      while (!fin && cyc < 3000) begin
         if (v.hold_len > 0 && reads == v.hold_at && held < v.hold_len) begin
            hold = 1'b1;
            held++;
         end else begin
            hold = 1'b0;
         end
         if (v.start_mid && reads == 20 && !mid_done) begin
            start = 1'b1;
            u_in = 3'd3;
            mid_done = 1;
         end else begin
            start = 1'b0;
         end
         #1;
         chk("busy_in_pass", busy, 1);
         chk("u_latched", u, v.u_in);
         if (hold) begin
            chk("rd_valid_hold", rd_valid, 0);
            chk("wr_valid_hold", wr_valid, 0);
            if (exp_q.size() > 0) chk("idx_frozen", {x, y, L, k}, exp_q[0]);
         end
         if (rd_valid) begin
            if (exp_q.size() == 0) chk("extra_read", 1, 0);
            else chk("rd_idx", {x, y, L, k}, exp_q.pop_front());
            wr_q.push_back({x, y, L});
            rc_q.push_back(cyc);
            last_x = x; last_y = y; last_l = L; last_k = k;
            reads++;
         end
         if (wr_valid) begin
            if (wr_q.size() == 0) begin
               chk("extra_write", 1, 0);
            end else begin
               w  = wr_q.pop_front();
               rc = rc_q.pop_front();
               chk("wr_xy", {x_Reg5, y_Reg5}, w[8:3]);
               chk("wr_z", z, (int'(w[2:0]) + 1) % zmod);
               if (v.hold_len == 0) chk("wr_lag", cyc - rc, 5);
            end
            if (!got_wr) first_z = z;
            got_wr = 1;
            last_z = z;
            wrs++;
         end
         if (done) begin
            fin = 1;
            chk("done_rd_overlap", rd_valid, 0);
         end
         cyc++;
         @(negedge clk);
      end
      hold  = 1'b0;
      start = 1'b0;

      chk("done_seen", fin, 1);
      chk("read_count", reads, v.exp_reads);
      chk("write_count", wrs, v.exp_reads);
      chk("pass_cycles", cyc, v.exp_cycles);
      chk("last_x", last_x, v.lx);
      chk("last_y", last_y, v.ly);
      chk("last_L", last_l, v.ll);
      chk("last_k", last_k, v.lk);
      chk("first_z", first_z, v.fz);
      chk("last_z", last_z, v.lz);
`ifdef L17_SEQ_CYCLE_CNT_EN
      exp_cnt = v.exp_cycles;
`else
      exp_cnt = 0;
`endif
      #1;
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
      chk("cycle_cnt", cycle_cnt, exp_cnt);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"}, x, 0);
      chk({tag, "_y"}, y, 0);
      chk({tag, "_L"}, L, 0);
      chk({tag, "_k"}, k, 1);
      chk({tag, "_u"}, u, 0);
      chk({tag, "_xr"}, x_Reg5, 0);
      chk({tag, "_yr"}, y_Reg5, 0);
      chk({tag, "_z"}, z, 0);
      chk({tag, "_rdv"}, rd_valid, 0);
      chk({tag, "_wrv"}, wr_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cnt"}, cycle_cnt, 0);
   endtask

   initial begin
      bit found;
      int no_done;

      //        u_in  hold_at len mid reads lx ly ll lk cycles fz lz
      tbl[0] = '{3'd0, -1,  0, 0, 512, 7, 7, 7, 1, 517, 1, 0};
      tbl[1] = '{3'd3, -1,  0, 0, 384, 3, 3, 7, 3, 389, 1, 0};
      tbl[2] = '{3'd2, -1,  0, 0,  64, 3, 3, 3, 1,  69, 1, 0};
      tbl[3] = '{3'd5, 40, 10, 0, 128, 3, 3, 7, 1, 143, 1, 0};
      tbl[4] = '{3'd5, -1,  0, 1, 128, 3, 3, 7, 1, 133, 1, 0};
      tbl[5] = '{3'd7,  0,  3, 0, 128, 3, 3, 7, 1, 136, 1, 0};
      tbl[6] = '{3'd1, -1,  0, 0, 512, 7, 7, 7, 1, 517, 1, 0};
      tbl[7] = '{3'd4, -1,  0, 0, 128, 3, 3, 7, 1, 133, 1, 0};

      repeat (3) @(negedge clk);
      #1;
      chk_reset_vals("rst_held");
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk_reset_vals("post_rst");

      for (int i = 0; i < 8; i++) run_pass(tbl[i]);

      // Reset in the middle of a mode-0 pass, once L has reached 3.
      @(negedge clk);
      start = 1'b1;
      u_in  = 3'd0;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 1000 && !found; c++) begin
         #1;
         if (rd_valid && L == 3'd3) found = 1;
         else @(negedge clk);
      end
      chk("rst_wait_L3", found, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      no_done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (done || busy) no_done++;
      end
      chk("rst_no_done", no_done, 0);

      run_pass(tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
